// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: default operand width and FSM state encodings.
package divider_pkg;

  localparam int DIV_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divider_5bits_trial_subtractor.sv
// Trial subtraction for one restoring step, built as a ripple chain of full adders.
// a - b is computed as a + ~b + 1; the final carry-out is high when no borrow occurred.

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module trial_subtractor
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] difference,
  output logic           no_borrow
);

  logic [WIDTH+1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_chain
    fullAdder u_fa (
      .a    (minuend[i]),
      .b    (~subtrahend[i]),
      .cin  (carry[i]),
      .sum  (difference[i]),
      .cout (carry[i+1])
    );
  end

  assign no_borrow = carry[WIDTH+1];

endmodule

// File: rtl/divider_5bits.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH iterations per division.
// A zero divisor skips the iterations and reports all-ones quotient with the dividend as remainder.
module divider_5bits
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             zero_pend_q, zero_pend_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial_diff;
  logic             no_borrow;
  logic             part_msb_unused;

  // shift_q starts as the dividend and fills with quotient bits from the right as MSBs leave.
  // The restored partial remainder is always below the divisor, so its MSB is clear before each shift.
  assign shifted         = {part_q[WIDTH-1:0], shift_q[WIDTH-1]};
  assign part_msb_unused = part_q[WIDTH];

  trial_subtractor #(.WIDTH(WIDTH)) u_trial (
    .minuend    (shifted),
    .subtrahend ({1'b0, divisor_q}),
    .difference (trial_diff),
    .no_borrow  (no_borrow)
  );

  // Next-state logic: accept start in IDLE/DONE, iterate in CALC, publish results on entry to DONE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    divisor_d   = divisor_q;
    part_d      = part_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    zero_pend_d = zero_pend_q;

    case (state_q)
      CALC: begin
        part_d  = no_borrow ? trial_diff : shifted;
        shift_d = {shift_q[WIDTH-2:0], no_borrow};
        if (count_q == '0) begin
          state_d = DONE;
          quot_d  = shift_d;
          rem_d   = part_d[WIDTH-1:0];
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        if (zero_pend_q) begin
          state_d     = DONE;
          zero_pend_d = 1'b0;
          quot_d      = '1;
          rem_d       = shift_q;
          dbz_d       = 1'b1;
        end else if (start) begin
          shift_d   = dividend;
          divisor_d = divisor;
          part_d    = '0;
          dbz_d     = 1'b0;
          count_d   = CNT_W'(WIDTH - 1);
          if (divisor == '0) begin
            state_d     = IDLE;
            zero_pend_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // All state and result registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      divisor_q   <= '0;
      part_q      <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      zero_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      divisor_q   <= divisor_d;
      part_q      <= part_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      zero_pend_q <= zero_pend_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_5bits.sv
// Directed and exhaustive checks of divider_5bits against an arithmetic reference model.
module tb_divider_5bits;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];

  divider_5bits #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge; drives one start cycle and queues the expected result.
  task automatic applyStimulus(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q   = 5'd31;
      e.r   = 5'(a);
      e.dbz = 1'b1;
    end else begin
      e.q   = 5'(a / b);
      e.r   = 5'(a % b);
      e.dbz = 1'b0;
    end
    sb.push_back(e);
    dividend = 5'(a);
    divisor  = 5'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checks latency and busy cycles, then pops and compares results.
  task automatic checkOutput(input int exp_lat, input bit exp_busy, input bit chk_after);
    int   lat;
    int   busy_cnt;
    exp_t e;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal("latency", lat, exp_lat);
    checkVal("busy_cycles", busy_cnt, exp_busy ? exp_lat : 0);
    checkVal("busy_with_done", busy, 0);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    checkVal("quotient", quotient, e.q);
    checkVal("remainder", remainder, e.r);
    checkVal("div_by_zero", div_by_zero, e.dbz);
    if (chk_after) begin
      @(posedge clk);
      #1;
      checkVal("done_single_pulse", done, 0);
      checkVal("busy_after_done", busy, 0);
      checkVal("quotient_hold", quotient, e.q);
      checkVal("remainder_hold", remainder, e.r);
      checkVal("dbz_hold", div_by_zero, e.dbz);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_busy", busy, 0);
    checkVal("reset_done", done, 0);
    checkVal("reset_quotient", quotient, 0);
    checkVal("reset_remainder", remainder, 0);
    checkVal("reset_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic divisions");
    applyStimulus(20, 3);  checkOutput(5, 1'b1, 1'b1);
    applyStimulus(31, 1);  checkOutput(5, 1'b1, 1'b1);
    applyStimulus(31, 31); checkOutput(5, 1'b1, 1'b1);
    applyStimulus(7, 10);  checkOutput(5, 1'b1, 1'b1);

    $display("[TB] divide by zero");
    applyStimulus(5, 0);   checkOutput(1, 1'b0, 1'b1);

    $display("[TB] start during CALC is ignored");
    applyStimulus(20, 3);
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 5'd9;
    divisor  = 5'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput(3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkVal("no_second_done", done, 0);
    end

    $display("[TB] reset mid-calculation");
    dividend = 5'd20;
    divisor  = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkVal("abort_busy", busy, 0);
    checkVal("abort_done", done, 0);
    checkVal("abort_quotient", quotient, 0);
    checkVal("abort_remainder", remainder, 0);
    checkVal("abort_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkVal("abort_no_done", done, 0);
    end
    applyStimulus(9, 2);   checkOutput(5, 1'b1, 1'b1);

    $display("[TB] reset beats start");
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 5'd20;
    divisor  = 5'd3;
    @(posedge clk);
    #1;
    checkVal("rst_prio_busy", busy, 0);
    checkVal("rst_prio_quotient", quotient, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkVal("rst_prio_idle", busy, 0);

    $display("[TB] start accepted in DONE");
    applyStimulus(20, 3);  checkOutput(5, 1'b1, 1'b0);
    applyStimulus(31, 31); checkOutput(5, 1'b1, 1'b1);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        applyStimulus(a, b);
        checkOutput((b == 0) ? 1 : 5, (b != 0), 1'b0);
      end
    end
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
